// File: rtl/store_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : store_monitor_if
// Description : Data-memory write port of the core as seen by the store
//               monitor. The core (or a bench) drives it through the master
//               modport. The monitor observes it through the slave modport.
//   MemWrite   1   store commits on this rising edge
//   DataAdr    32  store byte address
//   WriteData  32  store data
// Revision    : 1.0 - initial release
// ============================================================================
interface store_monitor_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;

    modport master (output MemWrite, output DataAdr, output WriteData);
    modport slave  (input  MemWrite, input  DataAdr, input  WriteData);
endinterface
`default_nettype wire

// File: rtl/store_monitor.sv
`default_nettype none
// ============================================================================
// Module      : store_monitor
// Description : End-of-program monitor on the core's data-memory write port.
//               Every committed store is classified on the edge at which it
//               commits:
//                 - the pass store (PASS_ADDR <- PASS_DATA) ends the run as PASS
//                 - stores to SCRATCH_ADDR are allowed
//                 - any other store ends the run as FAIL
//               A cycle watchdog ends a run that never finishes as TIMEOUT.
//               The terminal states hold until reset.
// Ports       :
//   clk          in   1      core clock, rising edge
//   reset        in   1      synchronous, active-high
//   bus          in   -      store port (MemWrite, DataAdr, WriteData)
//   done         out  1      run has ended
//   pass         out  1      run ended with the pass store
//   timeout      out  1      run ended by the watchdog
//   fail_adr     out  32     address of the offending store
//   fail_data    out  32     data of the offending store
//   store_count  out  CNT_W  stores seen in RUN, saturating
//   cycle_count  out  CNT_W  edges spent in RUN, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module store_monitor #(
    parameter logic [31:0] PASS_ADDR      = 32'd100,
    parameter logic [31:0] PASS_DATA      = 32'd7,
    parameter logic [31:0] SCRATCH_ADDR   = 32'd96,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CNT_W          = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    store_monitor_if.slave        bus,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [31:0]           fail_adr,
    output logic [31:0]           fail_data,
    output logic [CNT_W-1:0]      store_count,
    output logic [CNT_W-1:0]      cycle_count
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    // Last cycle_count value before the watchdog fires. The watchdog is only
    // armed when that value fits in the counter; a limit the counter can never
    // reach would otherwise alias onto a truncated compare value.
    localparam logic [63:0] c_tmo_last = 64'(TIMEOUT_CYCLES) - 64'd1;
    localparam bit          c_wdog_en  = (TIMEOUT_CYCLES != 0) &&
                                         ((c_tmo_last >> CNT_W) == 64'd0);

    state_t           r_state;
    logic             r_done;
    logic             r_pass;
    logic             r_timeout;
    logic [31:0]      r_fail_adr;
    logic [31:0]      r_fail_data;
    logic [CNT_W-1:0] r_store_count;
    logic [CNT_W-1:0] r_cycle_count;

    logic w_store;
    logic w_at_pass_adr;
    logic w_pass_data;
    logic w_at_scratch;
    logic w_tmo_hit;

    assign w_store       = bus.MemWrite;
    assign w_at_pass_adr = (bus.DataAdr == PASS_ADDR);
    assign w_pass_data   = (bus.WriteData == PASS_DATA);
    assign w_at_scratch  = (bus.DataAdr == SCRATCH_ADDR);
    assign w_tmo_hit     = c_wdog_en && (r_cycle_count == c_tmo_last[CNT_W-1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_timeout     <= 1'b0;
            r_fail_adr    <= 32'd0;
            r_fail_data   <= 32'd0;
            r_store_count <= '0;
            r_cycle_count <= '0;
        end else if (r_state == ST_RUN) begin
            // The exiting edge is still counted as an edge spent in RUN.
            if (r_cycle_count != c_cnt_max) begin
                r_cycle_count <= r_cycle_count + c_cnt_one;
            end

            if (w_store) begin
                if (r_store_count != c_cnt_max) begin
                    r_store_count <= r_store_count + c_cnt_one;
                end

                if (w_at_pass_adr && w_pass_data) begin
                    r_state <= ST_PASS;
                    r_done  <= 1'b1;
                    r_pass  <= 1'b1;
                end else if (w_at_pass_adr || !w_at_scratch) begin
                    // Wrong data at the pass address, or a store anywhere
                    // outside the scratch location.
                    r_state     <= ST_FAIL;
                    r_done      <= 1'b1;
                    r_fail_adr  <= bus.DataAdr;
                    r_fail_data <= bus.WriteData;
                end
            end else if (w_tmo_hit) begin
                // A store on the watchdog edge wins: the watchdog is only
                // consulted on edges without a store.
                r_state   <= ST_TIMEOUT;
                r_done    <= 1'b1;
                r_timeout <= 1'b1;
            end
        end
    end

    assign done        = r_done;
    assign pass        = r_pass;
    assign timeout     = r_timeout;
    assign fail_adr    = r_fail_adr;
    assign fail_data   = r_fail_data;
    assign store_count = r_store_count;
    assign cycle_count = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_store_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_monitor
// Description : Self-checking bench for store_monitor. Three instances cover
//               the default parameters, a 20-cycle watchdog and a 4-bit
//               counter width with the watchdog disabled. Expected outputs are
//               queued as each cycle is driven and compared after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_monitor;

    typedef struct packed {
        logic        dn;
        logic        ps;
        logic        to;
        logic [31:0] fa;
        logic [31:0] fd;
        logic [15:0] sc;
        logic [15:0] cc;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d, rst_t, rst_s;

    store_monitor_if bus_d ();
    store_monitor_if bus_t ();
    store_monitor_if bus_s ();

    logic        done_d, pass_d, tmo_d;
    logic [31:0] fa_d, fd_d;
    logic [15:0] sc_d, cc_d;

    logic        done_t, pass_t, tmo_t;
    logic [31:0] fa_t, fd_t;
    logic [15:0] sc_t, cc_t;

    logic        done_s, pass_s, tmo_s;
    logic [31:0] fa_s, fd_s;
    logic [3:0]  sc_s, cc_s;

    store_monitor u_dut_d (
        .clk(clk), .reset(rst_d), .bus(bus_d.slave),
        .done(done_d), .pass(pass_d), .timeout(tmo_d),
        .fail_adr(fa_d), .fail_data(fd_d),
        .store_count(sc_d), .cycle_count(cc_d)
    );

    store_monitor #(.TIMEOUT_CYCLES(20)) u_dut_t (
        .clk(clk), .reset(rst_t), .bus(bus_t.slave),
        .done(done_t), .pass(pass_t), .timeout(tmo_t),
        .fail_adr(fa_t), .fail_data(fd_t),
        .store_count(sc_t), .cycle_count(cc_t)
    );

    store_monitor #(.TIMEOUT_CYCLES(0), .CNT_W(4)) u_dut_s (
        .clk(clk), .reset(rst_s), .bus(bus_s.slave),
        .done(done_s), .pass(pass_s), .timeout(tmo_s),
        .fail_adr(fa_s), .fail_data(fd_s),
        .store_count(sc_s), .cycle_count(cc_s)
    );

    obs_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic obs_t mk(input bit dn, input bit ps, input bit to,
                                input logic [31:0] fa, input logic [31:0] fd,
                                input int sc, input int cc);
        obs_t r;
        r.dn = dn; r.ps = ps; r.to = to; r.fa = fa; r.fd = fd;
        r.sc = 16'(sc); r.cc = 16'(cc);
        return r;
    endfunction

    function automatic obs_t obs(input int sel);
        obs_t r;
        case (sel)
            0:       r = '{done_d, pass_d, tmo_d, fa_d, fd_d, sc_d, cc_d};
            1:       r = '{done_t, pass_t, tmo_t, fa_t, fd_t, sc_t, cc_t};
            default: r = '{done_s, pass_s, tmo_s, fa_s, fd_s, {12'd0, sc_s}, {12'd0, cc_s}};
        endcase
        return r;
    endfunction

    // One clock cycle on the selected instance: drive on the falling edge,
    // let the rising edge sample, return 1 time unit after it.
    task automatic cyc(input int sel, input logic r, input logic mw,
                       input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        case (sel)
            0: begin rst_d = r; bus_d.MemWrite = mw; bus_d.DataAdr = a; bus_d.WriteData = d; end
            1: begin rst_t = r; bus_t.MemWrite = mw; bus_t.DataAdr = a; bus_t.WriteData = d; end
            default: begin rst_s = r; bus_s.MemWrite = mw; bus_s.DataAdr = a; bus_s.WriteData = d; end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        obs_t e, o;
        cyc(0, 1, 1, 104, 7);
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        cyc(0, 1, 1, 104, 7);
        e = sb.pop_front(); o = obs(0); n_chk++;
        if (o !== e) $display("FAIL reset_state got=%h want=%h", o, e); else n_pass++;
    endtask

    task automatic test_pass_sequence;
        obs_t e, o;
        sb.push_back(mk(0, 0, 0, 0, 0, 1, 1));
        cyc(0, 0, 1, 96, 3);
        e = sb.pop_front(); o = obs(0); n_chk++;
        if (o !== e) $display("FAIL scratch_store1 got=%h want=%h", o, e); else n_pass++;
        sb.push_back(mk(0, 0, 0, 0, 0, 2, 2));
        cyc(0, 0, 1, 96, 4);
        e = sb.pop_front(); o = obs(0); n_chk++;
        if (o !== e) $display("FAIL scratch_store2 got=%h want=%h", o, e); else n_pass++;
        sb.push_back(mk(1, 1, 0, 0, 0, 3, 3));
        cyc(0, 0, 1, 100, 7);
        e = sb.pop_front(); o = obs(0); n_chk++;
        if (o !== e) $display("FAIL pass_store got=%h want=%h", o, e); else n_pass++;
        sb.push_back(mk(1, 1, 0, 0, 0, 3, 3));
        cyc(0, 0, 1, 200, 1);
        e = sb.pop_front(); o = obs(0); n_chk++;
        if (o !== e) $display("FAIL pass_sticky got=%h want=%h", o, e); else n_pass++;
    endtask

    task automatic test_fail_address;
        obs_t e, o;
        cyc(0, 1, 0, 0, 0);
        sb.push_back(mk(1, 0, 0, 104, 7, 1, 1));
        cyc(0, 0, 1, 104, 7);
        e = sb.pop_front(); o = obs(0); n_chk++;
        if (o !== e) $display("FAIL bad_address got=%h want=%h", o, e); else n_pass++;
        sb.push_back(mk(1, 0, 0, 104, 7, 1, 1));
        cyc(0, 0, 0, 0, 0);
        e = sb.pop_front(); o = obs(0); n_chk++;
        if (o !== e) $display("FAIL fail_hold_idle got=%h want=%h", o, e); else n_pass++;
        sb.push_back(mk(1, 0, 0, 104, 7, 1, 1));
        cyc(0, 0, 1, 100, 7);
        e = sb.pop_front(); o = obs(0); n_chk++;
        if (o !== e) $display("FAIL fail_ignores_pass got=%h want=%h", o, e); else n_pass++;
    endtask

    task automatic test_fail_data;
        obs_t e, o;
        cyc(0, 1, 0, 0, 0);
        sb.push_back(mk(1, 0, 0, 100, 8, 1, 1));
        cyc(0, 0, 1, 100, 8);
        e = sb.pop_front(); o = obs(0); n_chk++;
        if (o !== e) $display("FAIL bad_pass_data got=%h want=%h", o, e); else n_pass++;
    endtask

    task automatic test_back_to_back;
        obs_t e, o;
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // Pass address and data on the bus without MemWrite is not a store.
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 3));
        cyc(0, 0, 0, 100, 8);
        e = sb.pop_front(); o = obs(0); n_chk++;
        if (o !== e) $display("FAIL no_write_ignored got=%h want=%h", o, e); else n_pass++;
        cyc(0, 0, 1, 96, 0);
        sb.push_back(mk(0, 0, 0, 0, 0, 2, 5));
        cyc(0, 0, 1, 96, 32'hFFFF_FFFF);
        e = sb.pop_front(); o = obs(0); n_chk++;
        if (o !== e) $display("FAIL scratch_b2b got=%h want=%h", o, e); else n_pass++;
        // Address differing from the scratch address only in a low byte bit.
        sb.push_back(mk(1, 0, 0, 97, 5, 3, 6));
        cyc(0, 0, 1, 97, 5);
        e = sb.pop_front(); o = obs(0); n_chk++;
        if (o !== e) $display("FAIL near_scratch got=%h want=%h", o, e); else n_pass++;
    endtask

    task automatic test_timeout;
        obs_t e, o;
        cyc(1, 1, 0, 0, 0);
        repeat (18) cyc(1, 0, 0, 0, 0);
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 19));
        cyc(1, 0, 0, 0, 0);
        e = sb.pop_front(); o = obs(1); n_chk++;
        if (o !== e) $display("FAIL pre_timeout got=%h want=%h", o, e); else n_pass++;
        sb.push_back(mk(1, 0, 1, 0, 0, 0, 20));
        cyc(1, 0, 0, 0, 0);
        e = sb.pop_front(); o = obs(1); n_chk++;
        if (o !== e) $display("FAIL timeout_edge got=%h want=%h", o, e); else n_pass++;
        sb.push_back(mk(1, 0, 1, 0, 0, 0, 20));
        cyc(1, 0, 1, 100, 7);
        e = sb.pop_front(); o = obs(1); n_chk++;
        if (o !== e) $display("FAIL timeout_sticky got=%h want=%h", o, e); else n_pass++;
        // Store on the watchdog edge is classified instead.
        cyc(1, 1, 0, 0, 0);
        repeat (19) cyc(1, 0, 0, 0, 0);
        sb.push_back(mk(1, 1, 0, 0, 0, 1, 20));
        cyc(1, 0, 1, 100, 7);
        e = sb.pop_front(); o = obs(1); n_chk++;
        if (o !== e) $display("FAIL store_beats_watchdog got=%h want=%h", o, e); else n_pass++;
    endtask

    task automatic test_reset_midrun;
        obs_t e, o;
        cyc(0, 1, 0, 0, 0);
        sb.push_back(mk(1, 1, 0, 0, 0, 1, 1));
        cyc(0, 0, 1, 100, 7);
        e = sb.pop_front(); o = obs(0); n_chk++;
        if (o !== e) $display("FAIL reach_pass got=%h want=%h", o, e); else n_pass++;
        cyc(0, 0, 0, 0, 0);
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        cyc(0, 1, 1, 200, 1);
        e = sb.pop_front(); o = obs(0); n_chk++;
        if (o !== e) $display("FAIL reset_from_pass got=%h want=%h", o, e); else n_pass++;
        sb.push_back(mk(1, 0, 0, 200, 1, 1, 1));
        cyc(0, 0, 1, 200, 1);
        e = sb.pop_front(); o = obs(0); n_chk++;
        if (o !== e) $display("FAIL fail_after_reset got=%h want=%h", o, e); else n_pass++;
    endtask

    task automatic test_saturation;
        obs_t e, o;
        cyc(2, 1, 0, 0, 0);
        for (int i = 1; i <= 14; i++) cyc(2, 0, 1, 96, 32'(i));
        sb.push_back(mk(0, 0, 0, 0, 0, 15, 15));
        cyc(2, 0, 1, 96, 15);
        e = sb.pop_front(); o = obs(2); n_chk++;
        if (o !== e) $display("FAIL count_at_max got=%h want=%h", o, e); else n_pass++;
        for (int i = 16; i <= 19; i++) cyc(2, 0, 1, 96, 32'(i));
        sb.push_back(mk(0, 0, 0, 0, 0, 15, 15));
        cyc(2, 0, 1, 96, 20);
        e = sb.pop_front(); o = obs(2); n_chk++;
        if (o !== e) $display("FAIL count_saturated got=%h want=%h", o, e); else n_pass++;
    endtask

    initial begin
        rst_d = 1'b1; rst_t = 1'b1; rst_s = 1'b1;
        bus_d.MemWrite = 1'b0; bus_d.DataAdr = '0; bus_d.WriteData = '0;
        bus_t.MemWrite = 1'b0; bus_t.DataAdr = '0; bus_t.WriteData = '0;
        bus_s.MemWrite = 1'b0; bus_s.DataAdr = '0; bus_s.WriteData = '0;

        test_reset;
        test_pass_sequence;
        test_fail_address;
        test_fail_data;
        test_back_to_back;
        test_timeout;
        test_reset_midrun;
        test_saturation;

        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit got=expired want=finish");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
